axi_lite_arbiter_2x1: RTL

AXI_LITE_ARBITER_2X1 -- requirements
Module: axi_lite_arbiter_2x1

---
 rtl/axi_lite_arbiter_2x1.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_arbiter_2x1.sv
// Two-master to one-slave AXI4-Lite arbiter with round-robin grant and a single outstanding transaction.
// Data, strobe, prot and response fields are muxed combinationally by the registered owner.
module axi_lite_arbiter_2x1 #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    // m0: instruction fetch
    input  logic [ADDR_W-1:0]   m0_awaddr,
    input  logic [2:0]          m0_awprot,
    input  logic                m0_awvalid,
    output logic                m0_awready,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    input  logic                m0_wvalid,
    output logic                m0_wready,
    output logic [1:0]          m0_bresp,
    output logic                m0_bvalid,
    input  logic                m0_bready,
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic [2:0]          m0_arprot,
    input  logic                m0_arvalid,
    output logic                m0_arready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [1:0]          m0_rresp,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    // m1: load/store
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic [2:0]          m1_awprot,
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    output logic [1:0]          m1_bresp,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic [2:0]          m1_arprot,
    input  logic                m1_arvalid,
    output logic                m1_arready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [1:0]          m1_rresp,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    // shared memory
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic [2:0]          s_awprot,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wvalid,
    input  logic                s_wready,
    input  logic [1:0]          s_bresp,
    input  logic                s_bvalid,
    output logic                s_bready,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic [2:0]          s_arprot,
    output logic                s_arvalid,
    input  logic                s_arready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rvalid,
    output logic                s_rready,
    output logic [1:0]          grant_o
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t state_q, state_d;
    logic   own_q, own_d;
    logic   last_q, last_d;
    logic   ar_done_q, ar_done_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;

    logic req0, req1;
    logic o_arvalid, o_awvalid, o_wvalid, o_rready, o_bready;
    logic o_arready, o_awready, o_wready, o_rvalid, o_bvalid;
    logic [DATA_W-1:0] o_rdata;
    logic [1:0]        o_rresp, o_bresp;

    assign req0 = m0_arvalid | m0_awvalid | m0_wvalid;
    assign req1 = m1_arvalid | m1_awvalid | m1_wvalid;

    assign o_arvalid = own_q ? m1_arvalid : m0_arvalid;
    assign o_awvalid = own_q ? m1_awvalid : m0_awvalid;
    assign o_wvalid  = own_q ? m1_wvalid  : m0_wvalid;
    assign o_rready  = own_q ? m1_rready  : m0_rready;
    assign o_bready  = own_q ? m1_bready  : m0_bready;

    assign s_awaddr = own_q ? m1_awaddr : m0_awaddr;
    assign s_awprot = own_q ? m1_awprot : m0_awprot;
    assign s_wdata  = own_q ? m1_wdata  : m0_wdata;
    assign s_wstrb  = own_q ? m1_wstrb  : m0_wstrb;
    assign s_araddr = own_q ? m1_araddr : m0_araddr;
    assign s_arprot = own_q ? m1_arprot : m0_arprot;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            own_q     <= 1'b0;
            last_q    <= 1'b0;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            own_q     <= own_d;
            last_q    <= last_d;
            ar_done_q <= ar_done_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        own_d     = own_q;
        last_d    = last_q;
        ar_done_d = ar_done_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        s_arvalid = 1'b0;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_rready  = 1'b0;
        s_bready  = 1'b0;
        o_arready = 1'b0;
        o_awready = 1'b0;
        o_wready  = 1'b0;
        o_rvalid  = 1'b0;
        o_bvalid  = 1'b0;
        o_rdata   = '0;
        o_rresp   = 2'b00;
        o_bresp   = 2'b00;
        // Outputs stay quiet while rst is high so nothing leaks before the state register clears.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    ar_done_d = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (req0 | req1) begin
                        own_d   = (req0 & req1) ? ~last_q : req1;
                        state_d = (own_d ? m1_arvalid : m0_arvalid) ? RD : WR;
                    end
                end
                RD: begin
                    // Address handshake is masked once done so one grant carries one read.
                    s_arvalid = o_arvalid & ~ar_done_q;
                    o_arready = s_arready & ~ar_done_q;
                    if (s_arvalid & s_arready) ar_done_d = 1'b1;
                    s_rready = o_rready;
                    o_rvalid = s_rvalid;
                    o_rdata  = s_rdata;
                    o_rresp  = s_rresp;
                    if (s_rvalid & o_rready) begin
                        state_d = IDLE;
                        last_d  = own_q;
                    end
                end
                WR: begin
                    s_awvalid = o_awvalid & ~aw_done_q;
                    o_awready = s_awready & ~aw_done_q;
                    s_wvalid  = o_wvalid & ~w_done_q;
                    o_wready  = s_wready & ~w_done_q;
                    if (s_awvalid & s_awready) aw_done_d = 1'b1;
                    if (s_wvalid & s_wready) w_done_d = 1'b1;
                    s_bready = o_bready;
                    o_bvalid = s_bvalid;
                    o_bresp  = s_bresp;
                    if (s_bvalid & o_bready) begin
                        state_d = IDLE;
                        last_d  = own_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign m0_arready = o_arready & ~own_q;
    assign m0_awready = o_awready & ~own_q;
    assign m0_wready  = o_wready  & ~own_q;
    assign m0_rvalid  = o_rvalid  & ~own_q;
    assign m0_bvalid  = o_bvalid  & ~own_q;
    assign m0_rdata   = own_q ? '0 : o_rdata;
    assign m0_rresp   = own_q ? 2'b00 : o_rresp;
    assign m0_bresp   = own_q ? 2'b00 : o_bresp;

    assign m1_arready = o_arready & own_q;
    assign m1_awready = o_awready & own_q;
    assign m1_wready  = o_wready  & own_q;
    assign m1_rvalid  = o_rvalid  & own_q;
    assign m1_bvalid  = o_bvalid  & own_q;
    assign m1_rdata   = own_q ? o_rdata : '0;
    assign m1_rresp   = own_q ? o_rresp : 2'b00;
    assign m1_bresp   = own_q ? o_bresp : 2'b00;

    assign grant_o = (rst || state_q == IDLE) ? 2'b00 : (own_q ? 2'b10 : 2'b01);

endmodule
